// File: rtl/svm_stage1_engine_pkg.sv
// svm_pkg: shared FSM encodings and width helpers for the stage-1 SVM engine
package svm_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t LOAD   = 2'd1;
  localparam state_t REDUCE = 2'd2;
  localparam state_t FINAL  = 2'd3;
  function automatic int dot_w(int xlen_pixel, int num_pixels);
    return 2 * xlen_pixel + $clog2(num_pixels);
  endfunction
  function automatic int score_w(int xlen_pixel, int num_pixels, int xlen_coef, int num_sv);
    return dot_w(xlen_pixel, num_pixels) + xlen_coef + $clog2(num_sv) + 2;
  endfunction
  function automatic int lane_lo(int lane, int w);
    return lane * w;
  endfunction
endpackage

// File: rtl/svm_stage1_engine_if.sv
// svm_stage1_engine_if: control, pixel stream and result bus of the stage-1 engine
interface svm_stage1_engine_if #(
  parameter int XLEN_PIXEL    = 8,
  parameter int NUM_OF_PIXELS = 4,
  parameter int NUM_LANES     = 10,
  parameter int NUM_OF_SV     = 100,
  parameter int XLEN_COEF     = 16
);
  localparam int SCORE_W = svm_pkg::score_w(XLEN_PIXEL, NUM_OF_PIXELS, XLEN_COEF, NUM_OF_SV);
  logic en;
  logic start;
  logic busy;
  logic pix_valid;
  logic pix_ready;
  logic [XLEN_PIXEL-1:0] x_test;
  logic [NUM_LANES*XLEN_PIXEL-1:0] x_sv;
  logic [NUM_LANES*XLEN_COEF-1:0] coef;
  logic signed [XLEN_COEF-1:0] bias;
  logic signed [SCORE_W-1:0] score;
  logic y_class;
  logic done;
  modport master (
    output en, start, pix_valid, x_test, x_sv, coef, bias,
    input  busy, pix_ready, score, y_class, done
  );
  modport slave (
    input  en, start, pix_valid, x_test, x_sv, coef, bias,
    output busy, pix_ready, score, y_class, done
  );
endinterface

// File: rtl/svm_stage1_engine_mac_lane.sv
// mac_lane: unsigned pixel dot-product accumulator for one support vector
module mac_lane #(
  parameter int XLEN_PIXEL = 8,
  parameter int DOT_W      = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  acc_en,
  input  logic [XLEN_PIXEL-1:0] a,
  input  logic [XLEN_PIXEL-1:0] b,
  output logic [DOT_W-1:0]      dot
);
  always_ff @(posedge clk or posedge rst)
    if (rst) dot <= '0;
    else if (en) dot <= clr ? '0 : acc_en ? dot + DOT_W'(a) * DOT_W'(b) : dot;
endmodule

// File: rtl/svm_stage1_engine.sv
// svm_stage1_engine: parallel MAC lanes, serial signed coefficient reduction and sign decision
module svm_stage1_engine
  import svm_pkg::*;
#(
  parameter int XLEN_PIXEL    = 8,
  parameter int NUM_OF_PIXELS = 4,
  parameter int NUM_LANES     = 10,
  parameter int NUM_OF_SV     = 100,
  parameter int XLEN_COEF     = 16
) (
  input logic clk,
  input logic rst,
  svm_stage1_engine_if.slave bus
);
  localparam int DOT_W     = dot_w(XLEN_PIXEL, NUM_OF_PIXELS);
  localparam int SCORE_W   = score_w(XLEN_PIXEL, NUM_OF_PIXELS, XLEN_COEF, NUM_OF_SV);
  localparam int NUM_BATCH = NUM_OF_SV / NUM_LANES;
  localparam int PW        = $clog2(NUM_OF_PIXELS);
  localparam int LW        = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  localparam int BW        = NUM_BATCH > 1 ? $clog2(NUM_BATCH) : 1;
  if (NUM_OF_SV % NUM_LANES != 0) begin : g_bad_sv
    $error("NUM_OF_SV must be a multiple of NUM_LANES");
  end
  if (NUM_OF_PIXELS < 2) begin : g_bad_pix
    $error("NUM_OF_PIXELS must be at least 2");
  end
  state_t state;
  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] lane_cnt;
  logic [BW-1:0] batch_cnt;
  logic signed [XLEN_COEF-1:0] coef_r [NUM_LANES];
  logic [DOT_W-1:0] dot [NUM_LANES];
  logic signed [SCORE_W-1:0] acc, prod, fin, score;
  logic y_class, done, beat, last_pix, last_lane, last_batch, clr;
  assign beat       = state == LOAD && bus.pix_valid;
  assign last_pix   = pix_cnt == PW'(NUM_OF_PIXELS - 1);
  assign last_lane  = lane_cnt == LW'(NUM_LANES - 1);
  assign last_batch = batch_cnt == BW'(NUM_BATCH - 1);
  assign clr        = state == IDLE || (state == REDUCE && last_lane && !last_batch);
  // one shared multiplier walks the lanes: signed coef times zero-extended dot
  assign prod = $signed({{(SCORE_W-XLEN_COEF){coef_r[lane_cnt][XLEN_COEF-1]}}, coef_r[lane_cnt]})
              * $signed({{(SCORE_W-DOT_W){1'b0}}, dot[lane_cnt]});
  assign fin  = acc + $signed({{(SCORE_W-XLEN_COEF){bus.bias[XLEN_COEF-1]}}, bus.bias});
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    mac_lane #(.XLEN_PIXEL(XLEN_PIXEL), .DOT_W(DOT_W)) u_lane (
      .clk(clk), .rst(rst), .en(bus.en), .clr(clr), .acc_en(beat),
      .a(bus.x_test), .b(bus.x_sv[lane_lo(l, XLEN_PIXEL) +: XLEN_PIXEL]), .dot(dot[l])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      pix_cnt   <= '0;
      lane_cnt  <= '0;
      batch_cnt <= '0;
      acc       <= '0;
      score     <= '0;
      y_class   <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) coef_r[i] <= '0;
    end else if (bus.en) begin
      done <= state == FINAL;
      case (state)
        IDLE: begin
          acc       <= '0;
          pix_cnt   <= '0;
          lane_cnt  <= '0;
          batch_cnt <= '0;
          if (bus.start) state <= LOAD;
        end
        LOAD: if (bus.pix_valid) begin
          pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
          if (last_pix) begin
            for (int i = 0; i < NUM_LANES; i++) coef_r[i] <= bus.coef[i*XLEN_COEF +: XLEN_COEF];
            state <= REDUCE;
          end
        end
        REDUCE: begin
          acc      <= acc + prod;
          lane_cnt <= last_lane ? '0 : lane_cnt + 1'b1;
          if (last_lane) begin
            state     <= last_batch ? FINAL : LOAD;
            batch_cnt <= last_batch ? batch_cnt : batch_cnt + 1'b1;
          end
        end
        default: begin
          score   <= fin;
          y_class <= ~fin[SCORE_W-1];
          state   <= IDLE;
        end
      endcase
    end
  assign bus.busy      = state != IDLE;
  assign bus.pix_ready = state == LOAD;
  assign bus.score     = score;
  assign bus.y_class   = y_class;
  assign bus.done      = done;
endmodule

// File: tb/tb_svm_stage1_engine.sv
// tb_svm_stage1_engine: directed vectors and corner sequences for the stage-1 SVM engine
module tb_svm_stage1_engine;
  localparam int XP = 8, NP = 4, NL = 2, NS = 4, XC = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  svm_stage1_engine_if #(.XLEN_PIXEL(XP), .NUM_OF_PIXELS(NP), .NUM_LANES(NL), .NUM_OF_SV(NS), .XLEN_COEF(XC)) bus ();
  svm_stage1_engine #(.XLEN_PIXEL(XP), .NUM_OF_PIXELS(NP), .NUM_LANES(NL), .NUM_OF_SV(NS), .XLEN_COEF(XC)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  typedef struct {
    logic [7:0]         pix;
    logic signed [15:0] c0;
    logic signed [15:0] c1;
    logic signed [15:0] b;
    longint             sc;
    logic               y;
  } vec_t;
  vec_t vecs [5];
  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, act, exp);
    end
  endtask
  // starts a run from a negedge and returns at the negedge where done is seen
  task automatic run(input logic [7:0] p, input logic signed [15:0] c0, input logic signed [15:0] c1,
                     input logic signed [15:0] b, input int spv, input int sen, input longint prev,
                     output int lat, output logic held);
    int ens;
    ens = 0;
    lat = 0;
    held = 1'b1;
    bus.x_test = p;
    bus.x_sv = {p, p};
    bus.coef = {c1, c0};
    bus.bias = b;
    bus.pix_valid = 1'b1;
    bus.en = 1'b1;
    bus.start = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      bus.start = spv > 0 && k == 3;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (longint'(bus.score) != prev) held = 1'b0;
      bus.pix_valid = !(k >= 2 && k < 2 + spv);
      if (bus.busy && !bus.pix_ready && ens < sen) begin
        bus.en = 1'b0;
        ens++;
      end else bus.en = 1'b1;
    end
    bus.start = 1'b0;
    bus.en = 1'b1;
    bus.pix_valid = 1'b1;
  endtask
  initial begin
    int lat;
    logic held, seen;
    longint prev;
    bus.en = 1'b0;
    bus.start = 1'b0;
    bus.pix_valid = 1'b0;
    bus.x_test = '0;
    bus.x_sv = '0;
    bus.coef = '0;
    bus.bias = '0;
    vecs[0] = '{8'd1,   16'sd1,  16'sd1,  16'sd0,   64'sd16,       1'b1};
    vecs[1] = '{8'd255, -16'sd1, -16'sd1, 16'sd5,   -64'sd1040395, 1'b0};
    vecs[2] = '{8'd3,   16'sd1,  -16'sd1, 16'sd0,   64'sd0,        1'b1};
    vecs[3] = '{8'd2,   16'sd3,  -16'sd1, -16'sd20, 64'sd44,       1'b1};
    vecs[4] = '{8'd1,   -16'sd2, 16'sd1,  16'sd3,   -64'sd5,       1'b0};
    repeat (2) @(negedge clk);
    chk("rst_score", bus.score, 0);
    chk("rst_y", bus.y_class, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.pix_ready, 0);
    rst = 1'b0;
    bus.en = 1'b1;
    @(negedge clk);
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      run(vecs[i].pix, vecs[i].c0, vecs[i].c1, vecs[i].b, 0, 0, prev, lat, held);
      chk($sformatf("vec%0d_score", i), bus.score, vecs[i].sc);
      chk($sformatf("vec%0d_y", i), bus.y_class, vecs[i].y);
      chk($sformatf("vec%0d_latency", i), lat, 14);
      chk($sformatf("vec%0d_hold", i), held, 1);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), bus.done, 0);
      chk($sformatf("vec%0d_idle", i), bus.busy, 0);
      prev = vecs[i].sc;
    end
    run(8'd1, 16'sd1, 16'sd1, 16'sd0, 3, 2, prev, lat, held);
    chk("stall_score", bus.score, 16);
    chk("stall_latency", lat, 19);
    chk("stall_hold", held, 1);
    @(negedge clk);
    chk("stall_done_pulse", bus.done, 0);
    seen = 1'b0;
    bus.start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy && !bus.pix_ready) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reach_reduce", seen, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_score", bus.score, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ready", bus.pix_ready, 0);
    chk("midrst_done", bus.done, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 0);
    run(8'd1, 16'sd1, 16'sd1, 16'sd0, 0, 0, 0, lat, held);
    chk("fresh_score", bus.score, 16);
    chk("fresh_latency", lat, 14);
    chk("fresh_hold", held, 1);
    @(negedge clk);
    run(8'd1, 16'sd2, 16'sd2, 16'sd0, 0, 0, 16, lat, held);
    chk("b2b_score", bus.score, 32);
    chk("b2b_y", bus.y_class, 1);
    chk("b2b_latency", lat, 14);
    chk("b2b_hold16", held, 1);
    @(negedge clk);
    chk("b2b_done_pulse", bus.done, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/svm_stage1_engine.md
# svm_stage1_engine

Parametrised stage-1 SVM decision engine. It streams one test-vector pixel and NUM_LANES support-vector pixels per beat into NUM_LANES parallel MAC lanes. Each lane batch of dot products is reduced with signed per-SV coefficients (alpha·y) into a running score, and the bias is added at the end. The block emits the sign as the class decision. It sits between the BRAM fetch/control logic and the stage-2 cascade, and replaces the fixed 10-slice top that had no reduction or decision logic.

## Interface
Parameters:
- XLEN_PIXEL, 8, unsigned pixel width
- NUM_OF_PIXELS, 4, pixels per vector (≥2)
- NUM_LANES, 10, parallel MAC lanes
- NUM_OF_SV, 100, support vectors; must be a multiple of NUM_LANES (elaboration error otherwise)
- XLEN_COEF, 16, signed coefficient/bias width
- Derived: DOT_W = 2·XLEN_PIXEL + clog2(NUM_OF_PIXELS); SCORE_W = DOT_W + XLEN_COEF + clog2(NUM_OF_SV) + 2; NUM_BATCH = NUM_OF_SV/NUM_LANES

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  global enable; low freezes all state and outputs
- start  in  1  begin classification; honoured only in IDLE
- busy  out  1  high in any state other than IDLE
- pix_valid  in  1  beat valid
- pix_ready  out  1  high only in LOAD
- x_test  in  XLEN_PIXEL  test pixel for this beat
- x_sv  in  NUM_LANES·XLEN_PIXEL  lane l at bits [l·XLEN_PIXEL +: XLEN_PIXEL]
- coef  in  NUM_LANES·XLEN_COEF  signed alpha·y per lane; sampled only on the last beat of a batch
- bias  in  XLEN_COEF  signed; sampled in FINAL
- score  out  SCORE_W  signed decision value
- y_class  out  1  1 if score ≥ 0, else 0
- done  out  1  one-cycle pulse when score/y_class are updated

## Operation
- States: IDLE, LOAD, REDUCE, FINAL.
- IDLE:
  - start & en → LOAD.
  - Clear lane accumulators, the score accumulator, the pixel counter and the batch counter.
  - score and y_class keep their previous values; they are not cleared.
- LOAD:
  - A beat is accepted when pix_valid & pix_ready & en.
  - Each lane adds x_test·x_sv[l] (unsigned) to its DOT_W accumulator.
  - The pixel counter counts 0..NUM_OF_PIXELS-1.
  - On the last beat, capture coef into a lane register → REDUCE.
- REDUCE:
  - One lane per cycle, lane index 0..NUM_LANES-1.
  - acc += sign-extended coef[l] × zero-extended dot[l].
  - After lane NUM_LANES-1:
    - If this is the last batch → FINAL.
    - Otherwise clear the lane accumulators and the pixel counter, increment the batch counter → LOAD.
- FINAL:
  - score ← acc + sign-extended bias.
  - y_class ← ~score[MSB].
  - done ← 1 → IDLE.
- start outside IDLE is ignored.
- Upstream re-streams the same test vector for each batch.
- Arithmetic is full-width two's complement; no saturation. SCORE_W guarantees no overflow.

## Timing
- Reset values:
  - state IDLE; all accumulators and counters 0.
  - score 0, y_class 0, done 0, busy 0, pix_ready 0.
- rst takes effect immediately and asynchronously, including mid-LOAD or mid-REDUCE. Partial results are discarded and no done is produced.
- en low: no state, counter, accumulator or output changes. An in-flight done pulse is held until en returns. pix_ready stays at its state-derived value, but no beat is accepted.
- Latency with pix_valid held high and en high:
  - done is high in the cycle after edge NUM_BATCH·(NUM_OF_PIXELS + NUM_LANES) + 1, counting the start-sampling edge as edge 0.
  - Each pix_valid-low or en-low cycle in LOAD adds exactly one cycle.
- done is high for exactly one cycle. score and y_class are stable from the done cycle until the next FINAL.
- pix_ready is 0 throughout REDUCE and FINAL. Upstream must hold beats until ready.

## Structure
- Package svm_pkg holds:
  - the state enum;
  - width helper functions (clog2-based DOT_W, SCORE_W);
  - the lane-slice index helper.
- Sub-module mac_lane, instantiated NUM_LANES times:
  - inputs: clk, rst, en, clr, acc_en, a, b;
  - output: DOT_W unsigned accumulator.
- The top holds the FSM, the counters, the coef register and the single shared signed multiplier for REDUCE.

## Test plan
All scenarios use NUM_LANES=2, NUM_OF_SV=4, NUM_OF_PIXELS=4, XLEN_PIXEL=8, XLEN_COEF=16.
- Ones: all pixels 1, coef {+1,+1}, bias 0 → score=16, y_class=1; done high in the cycle after edge 13.
- Max magnitude: pixels 255, coef {-1,-1}, bias +5 → score=-1040395, y_class=0; no overflow.
- Zero boundary: pixels 3, coef {+1,-1}, bias 0 → score=0, y_class=1.
- Stalls: scenario 1 with 3 pix_valid-low cycles in LOAD and 2 en-low cycles in REDUCE → score=16, done delayed exactly 5 cycles; a second start while busy is ignored.
- Reset mid-REDUCE: assert rst during batch 0 REDUCE → next cycle score=0, busy=0, pix_ready=0, no done; a fresh run of scenario 1 → score=16.
- Back-to-back: start pulsed in the cycle after done with coef {+2,+2} → second done gives score=32; score holds 16 between the two done pulses.
